mult_result_buffer: RTL and testbench

MULT_RESULT_BUFFER -- requirements
Module: mult_result_buffer

---
 rtl/ariane_pkg.sv | 10 +
 rtl/riscv_pkg.sv | 5 +
 rtl/mult_result_buffer.sv | 117 +++++++++++
 tb/tb_mult_result_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared core types: the multiplier result buffer entry.
// Widths here are the core's defaults for the writeback path.
package ariane_pkg;
    localparam int unsigned TRANS_ID_W = 3;

    typedef struct packed {
        logic [riscv::XLEN-1:0] result;
        logic [TRANS_ID_W-1:0]  trans_id;
    } mult_entry_t;
endpackage

// File: rtl/riscv_pkg.sv
// Core-wide architectural constants.
// Only the datapath width is needed by the multiplier result buffer.
package riscv;
    localparam int unsigned XLEN = 64;
endpackage

// File: rtl/mult_result_buffer.sv
// Buffers multiplier results that cannot stall, in issue order, until writeback.
// Issue is throttled so buffered plus in-flight results never exceed DEPTH.
module mult_result_buffer
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = riscv::XLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_fire_i,
    output logic                     issue_ready_o,
    input  logic                     mult_valid_i,
    input  logic [XLEN-1:0]          mult_result_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     overflow_o
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned EXL = riscv::XLEN;
    localparam int unsigned EID = TRANS_ID_W;

    mult_entry_t   mem [DEPTH];
    mult_entry_t   in_entry;
    mult_entry_t   next_entry;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rnext;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic          full;
    logic          push;
    logic          pop;
    logic          accept;
    logic          drop;

    assign in_entry.result   = EXL'(mult_result_i);
    assign in_entry.trans_id = EID'(mult_trans_id_i);
    assign rnext             = rptr + PW'(1);
    assign next_entry        = mem[rnext];

    assign wb_valid_o = count != '0;
    assign full       = count == CW'(DEPTH);
    assign push       = mult_valid_i & ~flush_i;
    assign pop        = wb_valid_o & wb_ready_i & ~flush_i;
    assign accept     = push & (~full | pop);
    assign drop       = push & full & ~pop;

    assign issue_ready_o =
        ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wptr] <= in_entry;
        end
    end

    // The wb_* registers track the head: on a pop they load the entry
    // behind it, or the incoming result when that becomes the new head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr          <= '0;
            wptr          <= '0;
            count         <= '0;
            outstanding   <= '0;
            overflow_o    <= 1'b0;
            wb_result_o   <= '0;
            wb_trans_id_o <= '0;
        end else if (flush_i) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            outstanding <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rnext;
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (drop) begin
                overflow_o <= 1'b1;
            end
            case ({issue_fire_i, mult_valid_i})
                2'b10: begin
                    if (outstanding != CW'(DEPTH)) begin
                        outstanding <= outstanding + CW'(1);
                    end
                end
                2'b01: begin
                    if (outstanding != '0) begin
                        outstanding <= outstanding - CW'(1);
                    end
                end
                default: ;
            endcase
            if (pop && count > CW'(1)) begin
                wb_result_o   <= XLEN'(next_entry.result);
                wb_trans_id_o <= TRANS_ID_BITS'(next_entry.trans_id);
            end else if (accept && (!wb_valid_o || pop)) begin
                wb_result_o   <= mult_result_i;
                wb_trans_id_o <= mult_trans_id_i;
            end
        end
    end
endmodule

// File: tb/tb_mult_result_buffer.sv
// Directed bench for mult_result_buffer with a queue-based reference model.
// The model is checked every falling edge; literal checks pin key scenarios.
module tb_mult_result_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fire = 1'b0;
    logic        mv = 1'b0;
    logic [63:0] res = '0;
    logic [2:0]  id = '0;
    logic        rdy = 1'b0;
    logic        issue_ready;
    logic        wb_valid;
    logic [63:0] wb_result;
    logic [2:0]  wb_trans_id;
    logic        overflow;

    int n_checks = 0;
    int n_fail = 0;

    mult_result_buffer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .issue_fire_i   (fire),
        .issue_ready_o  (issue_ready),
        .mult_valid_i   (mv),
        .mult_result_i  (res),
        .mult_trans_id_i(id),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (rdy),
        .wb_result_o    (wb_result),
        .wb_trans_id_o  (wb_trans_id),
        .overflow_o     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r;
        logic [2:0]  id;
    } ent_t;

    ent_t q[$];
    int   m_out = 0;
    bit   m_ovf = 1'b0;

    // Reference model: an in-order queue bounded at DEPTH.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_out = 0;
            m_ovf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_out = 0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (mv) begin
                if (q.size() < DEPTH) q.push_back('{r: res, id: id});
                else m_ovf = 1'b1;
            end
            m_out = m_out + int'(fire) - int'(mv);
            if (m_out < 0) m_out = 0;
            if (m_out > DEPTH) m_out = DEPTH;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model wb_valid", 64'(wb_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("model wb_result", wb_result, q[0].r);
            chk("model wb_trans_id", 64'(wb_trans_id), 64'(q[0].id));
        end
        chk("model issue_ready", 64'(issue_ready),
            64'((q.size() + m_out) < DEPTH));
        chk("model overflow", 64'(overflow), 64'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [63:0] r, logic [2:0] i);
        mv = 1'b1;
        res = r;
        id = i;
        step();
        mv = 1'b0;
    endtask

    logic [63:0] exp_vals [4];

    initial begin
        #12;
        chk("rst wb_valid", 64'(wb_valid), 0);
        chk("rst issue_ready", 64'(issue_ready), 1);
        chk("rst overflow", 64'(overflow), 0);
        chk("rst wb_result", wb_result, 0);
        chk("rst wb_trans_id", 64'(wb_trans_id), 0);
        step();
        rst = 1'b0;
        step();

        fire = 1'b1;
        step();
        fire = 1'b0;
        chk("single ready in flight", 64'(issue_ready), 1);
        rdy = 1'b1;
        push(200, 3);
        chk("single wb_valid", 64'(wb_valid), 1);
        chk("single wb_result", wb_result, 200);
        chk("single wb_trans_id", 64'(wb_trans_id), 3);
        step();
        chk("single popped", 64'(wb_valid), 0);
        chk("single ready back", 64'(issue_ready), 1);

        fire = 1'b1;
        repeat (6) step();
        fire = 1'b0;
        chk("sat high ready", 64'(issue_ready), 0);
        push(5, 5);
        step();
        chk("sat high after one", 64'(issue_ready), 1);
        mv = 1'b1;
        repeat (4) step();
        mv = 1'b0;
        step();
        fire = 1'b1;
        repeat (4) step();
        fire = 1'b0;
        chk("sat low ready", 64'(issue_ready), 0);
        mv = 1'b1;
        repeat (4) step();
        mv = 1'b0;
        step();

        rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(64'(10 * (i + 1)), 3'(i));
        chk("order full ready", 64'(issue_ready), 0);
        chk("order head", wb_result, 10);
        step();
        chk("order head held", wb_result, 10);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("order drain result", wb_result, 64'(10 * (i + 1)));
            chk("order drain id", 64'(wb_trans_id), 64'(i));
            step();
        end
        chk("order empty", 64'(wb_valid), 0);

        rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(64'(i + 1), 3'(i + 4));
        rdy = 1'b1;
        push(50, 0);
        chk("pushpop overflow", 64'(overflow), 0);
        chk("pushpop still full", 64'(issue_ready), 0);
        exp_vals = '{64'd2, 64'd3, 64'd4, 64'd50};
        for (int i = 0; i < 4; i++) begin
            chk("pushpop drain", wb_result, exp_vals[i]);
            step();
        end
        chk("pushpop empty", 64'(wb_valid), 0);

        rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(64'(i + 5), 3'(i));
        push(99, 1);
        chk("ovf set", 64'(overflow), 1);
        chk("ovf head kept", wb_result, 5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ovf sticky", 64'(overflow), 1);
        chk("ovf flush empty", 64'(wb_valid), 0);

        push(11, 1);
        push(12, 2);
        fire = 1'b1;
        step();
        fire = 1'b0;
        chk("flush pre ready", 64'(issue_ready), 1);
        flush = 1'b1;
        mv = 1'b1;
        res = 77;
        id = 2;
        step();
        flush = 1'b0;
        mv = 1'b0;
        chk("flush wb_valid", 64'(wb_valid), 0);
        chk("flush issue_ready", 64'(issue_ready), 1);
        rdy = 1'b1;
        repeat (3) begin
            step();
            chk("flush nothing later", 64'(wb_valid), 0);
        end

        rdy = 1'b0;
        push(21, 1);
        push(22, 2);
        push(23, 3);
        chk("arst pre head", wb_result, 21);
        #2;
        rst = 1'b1;
        #1;
        chk("arst wb_valid", 64'(wb_valid), 0);
        chk("arst issue_ready", 64'(issue_ready), 1);
        chk("arst overflow", 64'(overflow), 0);
        chk("arst wb_result", wb_result, 0);
        chk("arst wb_trans_id", 64'(wb_trans_id), 0);
        step();
        rst = 1'b0;
        rdy = 1'b1;
        repeat (3) begin
            step();
            chk("arst no replay", 64'(wb_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
